// File: rtl/video_ram_arbiter_pkg.sv
// video_pkg: shared constants for the video/CPU RAM arbiter.
package video_pkg;

   localparam logic [14:0] WRAP_16K = 15'h4000;
   localparam logic [14:0] WRAP_8K  = 15'h2000;
   localparam logic [14:0] WRAP_20K = 15'h5000;
   localparam logic [14:0] WRAP_10K = 15'h2800;

   localparam logic [14:0] TTX_HI_BASE = 15'h7C00;
   localparam logic [14:0] TTX_LO_BASE = 15'h3C00;

   localparam logic [2:0] VID_LATCH  = 3'd3;
   localparam logic [2:0] CPU_SAMPLE = 3'd4;
   localparam logic [2:0] CPU_LATCH  = 3'd7;

   typedef enum logic [1:0] {CPU_IDLE, CPU_RD, CPU_WR} cpu_state_e;

   function automatic logic [14:0] wrap_size(input logic [1:0] ss);
      return ss[1] ? (ss[0] ? WRAP_10K : WRAP_20K) : (ss[0] ? WRAP_8K : WRAP_16K);
   endfunction

endpackage

// File: rtl/video_ram_arbiter_xlate.sv
// screen_addr_xlate: CRTC MA/RA to RAM address, with hardware-scroll wrap and teletext mapping.
module screen_addr_xlate
   import video_pkg::*;
(
   input  logic [13:0] crtc_ma_i,
   input  logic [2:0]  crtc_ra_i,
   input  logic [1:0]  screen_size_i,
   output logic [14:0] addr_o
);

   logic [14:0] raw;
   logic [14:0] gfx;
   logic [14:0] ttx;

   assign raw = {crtc_ma_i[11:0], crtc_ra_i};
   // Subtraction wraps naturally modulo 2^15.
   assign gfx = crtc_ma_i[12] ? raw - wrap_size(screen_size_i) : raw;
   assign ttx = (crtc_ma_i[11] ? TTX_HI_BASE : TTX_LO_BASE) | {5'd0, crtc_ma_i[9:0]};
   assign addr_o = crtc_ma_i[13] ? ttx : gfx;

endmodule

// File: rtl/video_ram_arbiter.sv
// video_ram_arbiter: time-slices a shared RAM between CRTC fetches (phases 0-3) and CPU accesses (phases 4-7).
module video_ram_arbiter
   import video_pkg::*;
#(
   parameter int RAM_AW = 15
) (
   input  logic              clk16MHz,
   input  logic              nRESET,
   input  logic              fast_crtc,
   input  logic [1:0]        screen_size,
   input  logic [13:0]       crtc_ma,
   input  logic [2:0]        crtc_ra,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [RAM_AW-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic [7:0]        vid_data,
   output logic              vid_valid
);

   logic [2:0]        phase_q, phase_d;
   logic              toggle_q, toggle_d;
   logic              fast_q, fast_d;
   logic [1:0]        ss_q, ss_d;
   cpu_state_e        cpu_st_q, cpu_st_d;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;
   logic [7:0]        cpu_rdata_q, cpu_rdata_d;
   logic              cpu_ready_q, cpu_ready_d;
   logic [7:0]        vid_data_q, vid_data_d;
   logic              vid_valid_q, vid_valid_d;
   logic              new_period;
   logic              vid_on_d;
   logic [14:0]       vid_addr;

   screen_addr_xlate u_xlate (
      .crtc_ma_i    (crtc_ma),
      .crtc_ra_i    (crtc_ra),
      .screen_size_i(ss_d),
      .addr_o       (vid_addr)
   );

   // Every register is loaded with the value for the phase it enters, so outputs are glitch-free.
   always_comb begin
      phase_d     = phase_q + 3'd1;
      new_period  = phase_q == 3'd7;
      toggle_d    = toggle_q ^ new_period;
      fast_d      = new_period ? fast_crtc : fast_q;
      ss_d        = new_period ? screen_size : ss_q;
      vid_on_d    = fast_d | toggle_d;
      cpu_st_d    = (phase_d == CPU_SAMPLE) ? (cpu_req ? (cpu_we ? CPU_WR : CPU_RD) : CPU_IDLE)
                  : (phase_d == 3'd0) ? CPU_IDLE : cpu_st_q;
      ram_addr_d  = (!phase_d[2] && vid_on_d) ? vid_addr
                  : (phase_d == CPU_SAMPLE && cpu_req) ? cpu_addr : ram_addr_q;
      ram_we_d    = cpu_st_q == CPU_WR && (phase_d == CPU_SAMPLE + 3'd1 || phase_d == CPU_LATCH - 3'd1);
      ram_wdata_d = (phase_d == CPU_SAMPLE && cpu_req && cpu_we) ? cpu_wdata : ram_wdata_q;
      cpu_ready_d = phase_d == CPU_LATCH && cpu_st_q != CPU_IDLE;
      cpu_rdata_d = (phase_d == CPU_LATCH && cpu_st_q == CPU_RD) ? ram_rdata : cpu_rdata_q;
      vid_valid_d = phase_d == VID_LATCH && vid_on_d;
      vid_data_d  = vid_valid_d ? ram_rdata : vid_data_q;
   end

   always_ff @(posedge clk16MHz) begin
      if (!nRESET) begin
         phase_q     <= 3'd0;
         toggle_q    <= 1'b0;
         fast_q      <= fast_crtc;
         ss_q        <= screen_size;
         cpu_st_q    <= CPU_IDLE;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= 8'd0;
         cpu_rdata_q <= 8'd0;
         cpu_ready_q <= 1'b0;
         vid_data_q  <= 8'd0;
         vid_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         toggle_q    <= toggle_d;
         fast_q      <= fast_d;
         ss_q        <= ss_d;
         cpu_st_q    <= cpu_st_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ready_q <= cpu_ready_d;
         vid_data_q  <= vid_data_d;
         vid_valid_q <= vid_valid_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ready = cpu_ready_q;
   assign vid_data  = vid_data_q;
   assign vid_valid = vid_valid_q;

endmodule

// File: tb/tb_video_ram_arbiter.sv
// tb_video_ram_arbiter: directed checks of slot timing, address translation and CPU access.
module tb_video_ram_arbiter;

   logic        clk16MHz = 1'b0;
   logic        nRESET = 1'b0;
   logic        fast_crtc = 1'b1;
   logic [1:0]  screen_size = 2'd0;
   logic [13:0] crtc_ma = 14'h0010;
   logic [2:0]  crtc_ra = 3'd5;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [14:0] cpu_addr = 15'd0;
   logic [7:0]  cpu_wdata = 8'd0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ready;
   logic [14:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  vid_data;
   logic        vid_valid;

   logic [7:0]  mem [32768];
   logic [14:0] a1 = 15'd0, a2 = 15'd0;
   logic [2:0]  tph = 3'd0;
   logic        tog = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   video_ram_arbiter #(.RAM_AW(15)) dut (
      .clk16MHz   (clk16MHz),
      .nRESET     (nRESET),
      .fast_crtc  (fast_crtc),
      .screen_size(screen_size),
      .crtc_ma    (crtc_ma),
      .crtc_ra    (crtc_ra),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .vid_data   (vid_data),
      .vid_valid  (vid_valid)
   );

   always #31 clk16MHz = ~clk16MHz;

   // RAM with two-cycle read latency, plus the bench's own phase/toggle reference.
   always @(posedge clk16MHz) begin
      a1 <= ram_addr;
      a2 <= a1;
      if (ram_we) mem[ram_addr] <= ram_wdata;
      tph <= nRESET ? tph + 3'd1 : 3'd0;
      tog <= !nRESET ? 1'b0 : tog ^ (tph == 3'd7);
   end
   assign ram_rdata = mem[a2];

   task automatic wait_ph(input int p, input int tg);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk16MHz);
         if (int'(tph) == p && (tg == 2 || int'(tog) == tg)) return;
      end
      n_chk++; n_fail++;
      $display("FAIL wait_ph: phase %0d toggle %0d not reached within 64 cycles", p, tg);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk16MHz);
      n_chk++; if (ram_addr !== 15'd0) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 0000", ram_addr); end
      n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
      n_chk++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_vid_valid: got %b want 0", vid_valid); end
      n_chk++; if (vid_data !== 8'd0) begin n_fail++; $display("FAIL rst_vid_data: got %h want 00", vid_data); end
      n_chk++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_ready); end
      n_chk++; if (cpu_rdata !== 8'd0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
      nRESET = 1'b1;
   endtask

   task automatic test_fast();
      int pulses = 0;
      wait_ph(7, 2);
      wait_ph(3, 2);
      n_chk++; if (ram_addr !== 15'h0085) begin n_fail++; $display("FAIL fast_addr: got %h want 0085", ram_addr); end
      n_chk++; if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL fast_valid: got %b want 1", vid_valid); end
      n_chk++; if (vid_data !== 8'hA5) begin n_fail++; $display("FAIL fast_data: got %h want a5", vid_data); end
      wait_ph(7, 2);
      for (int k = 0; k < 32; k++) begin
         @(negedge clk16MHz);
         pulses += int'(vid_valid);
         n_chk++; if (vid_valid !== (tph == 3'd3)) begin n_fail++; $display("FAIL fast_strobe: phase %0d got %b want %b", tph, vid_valid, tph == 3'd3); end
      end
      n_chk++; if (pulses != 4) begin n_fail++; $display("FAIL fast_count: got %0d want 4", pulses); end
   endtask

   task automatic test_slow();
      int pulses = 0;
      fast_crtc = 1'b0;
      wait_ph(7, 2);
      for (int k = 0; k < 32; k++) begin
         @(negedge clk16MHz);
         pulses += int'(vid_valid);
         n_chk++; if (vid_valid !== (tph == 3'd3 && tog)) begin n_fail++; $display("FAIL slow_strobe: phase %0d tog %b got %b want %b", tph, tog, vid_valid, tph == 3'd3 && tog); end
         n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL slow_we: phase %0d got %b want 0", tph, ram_we); end
      end
      n_chk++; if (pulses != 2) begin n_fail++; $display("FAIL slow_count: got %0d want 2", pulses); end
      wait_ph(0, 0);
      crtc_ma = 14'h0020;
      wait_ph(3, 0);
      n_chk++; if (ram_addr !== 15'h0085) begin n_fail++; $display("FAIL slow_hold_addr: got %h want 0085", ram_addr); end
      n_chk++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL slow_hold_valid: got %b want 0", vid_valid); end
      wait_ph(3, 1);
      n_chk++; if (ram_addr !== 15'h0105) begin n_fail++; $display("FAIL slow_new_addr: got %h want 0105", ram_addr); end
      n_chk++; if (vid_data !== 8'h3C) begin n_fail++; $display("FAIL slow_new_data: got %h want 3c", vid_data); end
   endtask

   task automatic test_wrap();
      logic [14:0] exp_w [4];
      exp_w = '{15'h7000, 15'h1000, 15'h6000, 15'h0800};
      fast_crtc = 1'b1;
      crtc_ma = 14'h1600;
      crtc_ra = 3'd0;
      for (int s = 0; s < 4; s++) begin
         screen_size = 2'(s);
         wait_ph(7, 2);
         wait_ph(3, 2);
         n_chk++; if (ram_addr !== exp_w[s]) begin n_fail++; $display("FAIL wrap_ss%0d: got %h want %h", s, ram_addr, exp_w[s]); end
      end
   endtask

   task automatic test_teletext();
      logic [13:0] ma [4];
      logic [14:0] exp_t [4];
      ma = '{14'h2005, 14'h2805, 14'h3805, 14'h23FF};
      exp_t = '{15'h3C05, 15'h7C05, 15'h7C05, 15'h3FFF};
      crtc_ra = 3'd7;
      screen_size = 2'd1;
      for (int t = 0; t < 4; t++) begin
         crtc_ma = ma[t];
         wait_ph(7, 2);
         wait_ph(3, 2);
         n_chk++; if (ram_addr !== exp_t[t]) begin n_fail++; $display("FAIL ttx_%h: got %h want %h", ma[t], ram_addr, exp_t[t]); end
      end
      crtc_ma = 14'h0010;
      crtc_ra = 3'd5;
      screen_size = 2'd0;
   endtask

   task automatic test_cpu_write();
      wait_ph(6, 2);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'h3A;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk16MHz);
         n_chk++; if (ram_we !== (k == 6 || k == 7)) begin n_fail++; $display("FAIL wr_we_k%0d: phase %0d got %b want %b", k, tph, ram_we, k == 6 || k == 7); end
         n_chk++; if (cpu_ready !== (k == 8)) begin n_fail++; $display("FAIL wr_ready_k%0d: phase %0d got %b want %b", k, tph, cpu_ready, k == 8); end
         if (k == 6) begin
            n_chk++; if (ram_addr !== 15'h1234) begin n_fail++; $display("FAIL wr_addr: got %h want 1234", ram_addr); end
            n_chk++; if (ram_wdata !== 8'h3A) begin n_fail++; $display("FAIL wr_wdata: got %h want 3a", ram_wdata); end
            cpu_addr = 15'h0999; cpu_we = 1'b0; cpu_wdata = 8'h00;
         end
         if (k == 7) begin
            n_chk++; if (ram_addr !== 15'h1234) begin n_fail++; $display("FAIL wr_addr_latched: got %h want 1234", ram_addr); end
         end
         if (k == 8) cpu_req = 1'b0;
      end
      n_chk++; if (mem[15'h1234] !== 8'h3A) begin n_fail++; $display("FAIL wr_mem: got %h want 3a", mem[15'h1234]); end
      n_chk++; if (mem[15'h0999] !== 8'h90) begin n_fail++; $display("FAIL wr_mem_untouched: got %h want 90", mem[15'h0999]); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk16MHz);
         n_chk++; if (cpu_ready !== 1'b0 || ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_idle: phase %0d ready %b we %b want 0 0", tph, cpu_ready, ram_we); end
      end
   endtask

   task automatic test_back_to_back();
      wait_ph(2, 2);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0456;
      wait_ph(7, 2);
      n_chk++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rd1_ready: got %b want 1", cpu_ready); end
      n_chk++; if (cpu_rdata !== 8'h5C) begin n_fail++; $display("FAIL rd1_data: got %h want 5c", cpu_rdata); end
      cpu_addr = 15'h0457;
      wait_ph(6, 2);
      n_chk++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rd2_early: got %b want 0", cpu_ready); end
      n_chk++; if (ram_addr !== 15'h0457) begin n_fail++; $display("FAIL rd2_addr: got %h want 0457", ram_addr); end
      wait_ph(7, 2);
      n_chk++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rd2_ready: got %b want 1", cpu_ready); end
      n_chk++; if (cpu_rdata !== 8'h5D) begin n_fail++; $display("FAIL rd2_data: got %h want 5d", cpu_rdata); end
      cpu_req = 1'b0;
   endtask

   task automatic test_reset_abort();
      wait_ph(2, 2);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0456;
      wait_ph(5, 2);
      nRESET = 1'b0;
      @(negedge clk16MHz);
      n_chk++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", cpu_ready); end
      n_chk++; if (cpu_rdata !== 8'd0) begin n_fail++; $display("FAIL abort_rdata: got %h want 00", cpu_rdata); end
      n_chk++; if (ram_addr !== 15'd0) begin n_fail++; $display("FAIL abort_addr: got %h want 0000", ram_addr); end
      @(negedge clk16MHz);
      nRESET = 1'b1;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk16MHz);
         n_chk++; if (cpu_ready !== (k == 7)) begin n_fail++; $display("FAIL abort_rel_ready_p%0d: got %b want %b", k, cpu_ready, k == 7); end
         n_chk++; if (vid_valid !== (k == 3)) begin n_fail++; $display("FAIL abort_rel_valid_p%0d: got %b want %b", k, vid_valid, k == 3); end
         n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL abort_rel_we_p%0d: got %b want 0", k, ram_we); end
         if (k == 3) begin
            n_chk++; if (ram_addr !== 15'h0085) begin n_fail++; $display("FAIL abort_rel_vaddr: got %h want 0085", ram_addr); end
         end
      end
      n_chk++; if (cpu_rdata !== 8'h5C) begin n_fail++; $display("FAIL abort_rel_rdata: got %h want 5c", cpu_rdata); end
      cpu_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 8'(i ^ (i >> 8));
      mem[15'h0085] = 8'hA5;
      mem[15'h0105] = 8'h3C;
      mem[15'h0456] = 8'h5C;
      mem[15'h0457] = 8'h5D;
      test_reset();
      test_fast();
      test_slow();
      test_wrap();
      test_teletext();
      test_cpu_write();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/video_ram_arbiter.md
VIDEO_RAM_ARBITER -- requirements
Module: video_ram_arbiter

Interface
REQ-001 Parameter: RAM_AW, 15, shared RAM address width (32 KB).
REQ-002 Reset is nRESET, synchronous, active-low; the clock is clk16MHz.
REQ-003 clk16MHz  in  1  system clock; all state updates on its rising edge.
REQ-004 nRESET  in  1  synchronous active-low reset.
REQ-005 fast_crtc  in  1  1 = CRTC at 2 MHz (video slot every 2 MHz period); 0 = 1 MHz (video slot every second period).
REQ-006 screen_size  in  2  addressable-latch bits B5:B4 selecting hardware-scroll wrap size.
REQ-007 crtc_ma  in  14  CRTC memory address; bit 13 selects teletext mapping.
REQ-008 crtc_ra  in  3  CRTC raster address.
REQ-009 cpu_req, cpu_we  in  1 each  CPU access request (level, held until cpu_ready) and write strobe.
REQ-010 cpu_addr  in  15; cpu_wdata  in  8  CPU address and write data.
REQ-011 cpu_rdata  out  8; cpu_ready  out  1  CPU read data and one-cycle completion pulse.
REQ-012 ram_addr  out  15; ram_we  out  1; ram_wdata  out  8; ram_rdata  in  8  shared RAM port (read data valid 2 cycles after address).
REQ-013 vid_data  out  8; vid_valid  out  1  fetched display byte and one-cycle strobe to the pixel shifter.

Function
REQ-014 A free-running 3-bit phase counter SHALL divide clk16MHz into 8-cycle (2 MHz) periods; a 1-bit period toggle SHALL advance at phase 7.
REQ-015 Phases 0-3 SHALL form the video slot, phases 4-7 the CPU slot; slots never overlap.
REQ-016 Video slot SHALL be active when fast_crtc=1, or when fast_crtc=0 and period toggle=1; otherwise ram_addr holds, ram_we=0, vid_valid stays 0.
REQ-017 Active video slot: ram_addr = translated address at phase 0-3; ram_rdata captured into vid_data at phase 3; vid_valid=1 during phase 3 only.
REQ-018 Graphics translation (crtc_ma[13]=0): raw = {crtc_ma[11:0], crtc_ra}; if crtc_ma[12]=1 raw is reduced by wrap size modulo 2^15.
REQ-019 Wrap size by screen_size: 00 -> 0x4000, 01 -> 0x2000, 10 -> 0x5000, 11 -> 0x2800.
REQ-020 Teletext translation (crtc_ma[13]=1): address = 0x7C00 | crtc_ma[9:0]; crtc_ra and screen_size ignored; if crtc_ma[11]=0 address = 0x3C00 | crtc_ma[9:0].
REQ-021 cpu_req SHALL be sampled only at phase 4; a request rising at phases 5-3 waits for the next phase 4.
REQ-022 Granted CPU slot: ram_addr = cpu_addr phases 4-7; read: cpu_rdata captured at phase 7; write: ram_wdata = cpu_wdata, ram_we=1 at phases 5-6 only.
REQ-023 cpu_ready SHALL pulse at phase 7 of a granted slot; cpu_req still high at the next phase 4 starts a new access.
REQ-024 cpu_addr/cpu_we changes after phase 4 SHALL be ignored for the current slot (latched at phase 4).
REQ-025 Changes of fast_crtc or screen_size take effect at the next phase 0; no slot is truncated.
REQ-026 ram_we SHALL never assert during a video slot.

Reset
REQ-027 On nRESET=0: phase=0, toggle=0, cpu_ready=0, vid_valid=0, ram_we=0, ram_addr=0, vid_data=0, cpu_rdata=0, CPU grant cleared.
REQ-028 Reset mid-access SHALL abort it without cpu_ready; first slot after release is a video slot at phase 0.

Structure
REQ-029 Shared package video_pkg SHALL hold the wrap-size constants, teletext base addresses and phase constants (VID_LATCH=3, CPU_SAMPLE=4, CPU_LATCH=7).
REQ-030 Address translation SHALL be one combinational sub-module, screen_addr_xlate.

Verification
REQ-031 fast_crtc=1, ma=0x0010, ra=5, ram returns 0xA5 -> ram_addr=0x0085, vid_valid at phase 3 every 8 cycles, vid_data=0xA5.
REQ-032 fast_crtc=0 -> vid_valid every 16 cycles; no RAM activity in inactive video slot.
REQ-033 ma=0x1600, ra=0, screen_size=10 -> raw 0x3000, ram_addr=0x6000 (0x3000-0x5000 mod 32K); screen_size=11 -> 0x0800.
REQ-034 ma=0x2005 -> ram_addr=0x3C05; ma=0x2805 -> 0x7C05.
REQ-035 cpu_req write 0x3A to 0x1234 raised at phase 6 -> waits; ram_we phases 5-6 of next CPU slot, cpu_ready at phase 7, no ram_we in video slots.
REQ-036 nRESET low at phase 5 of CPU read -> no cpu_ready; after release, phase 0 video slot, request serviced at following phase 4.
